// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    // Width of one adder slice.
    localparam int SLICE_W = 32;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An operand width is usable only if it splits into at least two whole slices.
    function automatic bit width_ok(input int w);
        return ((w % SLICE_W) == 0) && (w >= 2 * SLICE_W);
    endfunction

endpackage

// File: rtl/Prefix_adder32bit.sv
// 32-bit Kogge-Stone prefix adder with carry-in and carry-out.
// Level 0 forms bitwise generate/propagate. Each later level doubles the span
// of the group terms. The final group generate/propagate pair is then combined
// with cin to give every bit's carry.
module Prefix_adder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    genvar lv, gi;

    // Each level is kept in its own generate scope, so every level is a distinct
    // net and no bus feeds back into itself.
    for (lv = 0; lv <= 5; lv++) begin : stg
        logic [31:0] gl;
        logic [31:0] pl;
        if (lv == 0) begin : g_base
            assign gl = a & b;
            assign pl = a ^ b;
        end else begin : g_level
            localparam int D = 1 << (lv - 1);
            for (gi = 0; gi < 32; gi++) begin : g_bit
                if (gi >= D) begin : g_merge
                    assign gl[gi] = stg[lv-1].gl[gi] | (stg[lv-1].pl[gi] & stg[lv-1].gl[gi-D]);
                    assign pl[gi] = stg[lv-1].pl[gi] & stg[lv-1].pl[gi-D];
                end else begin : g_pass
                    assign gl[gi] = stg[lv-1].gl[gi];
                    assign pl[gi] = stg[lv-1].pl[gi];
                end
            end
        end
    end

    logic [31:0] carry_vec;

    // Build the carry into bit i from the group terms over bits [i-1:0], plus cin.
    always_comb begin
        carry_vec[0]    = cin;
        carry_vec[31:1] = stg[5].gl[30:0] | (stg[5].pl[30:0] & {31{cin}});
    end

    assign sum  = stg[0].pl ^ carry_vec;
    assign cout = stg[5].gl[31] | (stg[5].pl[31] & cin);

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer. The design reuses one 32-bit prefix
// adder across NSLICE cycles. It works from the LSB slice upward and chains the
// carry through a register.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("mp_add_sequencer: WIDTH must be a multiple of 32 and at least 64");
    end

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   opa_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               overflow_reg;

    logic               accept;
    logic               step;
    logic               last_step;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Select the operand slices for the current index.
    always_comb begin
        slice_a = opa_reg[idx_reg*SLICE_W +: SLICE_W];
        slice_b = opb_reg[idx_reg*SLICE_W +: SLICE_W];
    end

    Prefix_adder32bit u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs. Requests are taken only in IDLE,
    // so a result consumed in DONE is never overlapped with a new accept.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and final flag capture.
    // Subtraction is formed as a + ~b + 1, so the inversion happens here at load time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            opa_reg   <= a;
            opb_reg   <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
        end else if (step) begin
            sum_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_sum;
            carry_reg <= slice_cout;
            idx_reg   <= idx_reg + 1'b1;
            if (last_step) begin
                cout_reg     <= slice_cout;
                overflow_reg <= (opa_reg[WIDTH-1] == opb_reg[WIDTH-1]) &&
                                (slice_sum[SLICE_W-1] != opa_reg[WIDTH-1]);
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer at WIDTH=128. A scoreboard queue gets each
// expected result at its accept edge. The entry is popped when the result shows up.
module tb_mp_add_sequencer;

    localparam int W  = 128;
    localparam int NS = W / 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mp_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // Reference result taken straight from the arithmetic definition.
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic cc, input logic ss);
        exp_t         r;
        logic [W-1:0] ob;
        logic [W:0]   full;
        ob     = ss ? ~bb : bb;
        full   = {1'b0, aa} + {1'b0, ob} + {{W{1'b0}}, (ss ? 1'b1 : cc)};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (aa[W-1] == ob[W-1]) && (r.sum[W-1] != aa[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Drive one request, wait for it to be accepted, push its expectation, then
    // scramble the inputs to show they are not resampled. Returns at accept edge + 1.
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic cc, input logic ss);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", W'(in_ready), W'(1));
        a = aa; b = bb; cin = cc; sub = ss;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(aa, bb, cc, ss));
        #1;
        in_valid = 1'b0;
        a = ~aa; b = ~bb; cin = ~cc; sub = ~ss;
        $display("send a=%h b=%h cin=%0b sub=%0b", aa, bb, cc, ss);
    endtask

    // Called at accept edge + 1. Measures latency, compares against the
    // scoreboard, holds off the consumer for 'hold' cycles, then completes the handshake.
    task automatic collect(input string tag, input int hold);
        int   n;
        exp_t e;
        e = '0;
        chk({tag, "_busy_run"}, W'(busy), W'(1));
        chk({tag, "_in_ready_run"}, W'(in_ready), W'(0));
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, W'(n), W'(NS));
        n_checks++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard, expected an entry", tag);
        end
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk({tag, "_sum"}, sum, e.sum);
        chk({tag, "_cout"}, W'(cout), W'(e.cout));
        chk({tag, "_ovf"}, W'(overflow), W'(e.ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
            chk({tag, "_hold_ready"}, W'(in_ready), W'(0));
            chk({tag, "_hold_sum"}, sum, e.sum);
            chk({tag, "_hold_cout"}, W'(cout), W'(e.cout));
            chk({tag, "_hold_ovf"}, W'(overflow), W'(e.ovf));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, W'(out_valid), W'(0));
        chk({tag, "_idle_ready"}, W'(in_ready), W'(1));
        chk({tag, "_idle_busy"}, W'(busy), W'(0));
        $display("result %s sum=%h cout=%0b ovf=%0b latency=%0d", tag, sum, cout, overflow, n);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic         seen;
        ones      = '1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(overflow), W'(0));
        rst = 1'b0;

        // Carry crossing the slice 0/1 boundary.
        send(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0);
        collect("carry_cross", 0);

        // Full ripple through all slices.
        send(ones, '0, 1'b1, 1'b0);
        collect("full_ripple", 0);

        // Subtract with a borrow; cin must be ignored.
        send(128'd5, 128'd7, 1'b1, 1'b1);
        collect("sub_borrow", 0);

        // Signed overflow.
        send({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
        collect("signed_ovf", 0);

        // Back-pressure with a second request held pending throughout.
        send(128'h1111_2222_3333_4444_5555_6666_7777_8888,
             128'h8888_7777_6666_5555_4444_3333_2222_1111, 1'b1, 1'b0);
        a = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        b = 128'h0000_0000_0000_0001_0000_0000_0000_0002;
        cin = 1'b0;
        sub = 1'b1;
        in_valid = 1'b1;
        collect("backpressure", 10);
        @(posedge clk);
        sb_q.push_back(model(a, b, cin, sub));
        #1;
        in_valid = 1'b0;
        collect("bp_second", 0);

        // Randomised operations, alternating add and subtract.
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'(i % 2));
            collect("random", 0);
        end

        // Reset during the third RUN cycle.
        send({4{32'h1234_5678}}, {4{32'h0101_0101}}, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_sum", sum, '0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", W'(seen), W'(0));
        send(128'd1, 128'd2, 1'b0, 1'b0);
        collect("after_rst", 0);
        chk("after_rst_sum3", sum, 128'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
